// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: advance / hold / bubble / flush with multi-cycle scratch carry.
// Optional perf counters (bubble_cnt, hold_cnt) enabled by defining PIPE_REG_PERF_EN.
module pipe_stage_reg #(
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       ADDR_W    = 5,
   parameter int unsigned       ALUOP_W   = 8,
   parameter int unsigned       CARRY_W   = 66,
   parameter int unsigned       STALL_W   = 6,
   parameter int unsigned       STAGE     = 3,
   parameter logic [ALUOP_W-1:0] NOP_ALUOP = '0,
   parameter int unsigned       PERF_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic               in_valid,
   input  logic [ADDR_W-1:0]  in_wd,
   input  logic               in_wreg,
   input  logic [DATA_W-1:0]  in_wdata,
   input  logic [DATA_W-1:0]  in_hi,
   input  logic [DATA_W-1:0]  in_lo,
   input  logic               in_whilo,
   input  logic [DATA_W-1:0]  in_mem_addr,
   input  logic [DATA_W-1:0]  in_reg2,
   input  logic [ALUOP_W-1:0] in_aluop,
   input  logic [CARRY_W-1:0] carry_i,
   output logic               out_valid,
   output logic [ADDR_W-1:0]  out_wd,
   output logic               out_wreg,
   output logic [DATA_W-1:0]  out_wdata,
   output logic [DATA_W-1:0]  out_hi,
   output logic [DATA_W-1:0]  out_lo,
   output logic               out_whilo,
   output logic [DATA_W-1:0]  out_mem_addr,
   output logic [DATA_W-1:0]  out_reg2,
   output logic [ALUOP_W-1:0] out_aluop,
   output logic [CARRY_W-1:0] carry_o,
   output logic [PERF_W-1:0]  bubble_cnt,
   output logic [PERF_W-1:0]  hold_cnt
);

   typedef struct packed {
      logic               valid;
      logic [ADDR_W-1:0]  wd;
      logic               wreg;
      logic [DATA_W-1:0]  wdata;
      logic [DATA_W-1:0]  hi;
      logic [DATA_W-1:0]  lo;
      logic               whilo;
      logic [DATA_W-1:0]  mem_addr;
      logic [DATA_W-1:0]  reg2;
      logic [ALUOP_W-1:0] aluop;
   } slot_t;

   typedef enum logic [2:0] {
      ACT_RESET, ACT_FLUSH, ACT_BUBBLE, ACT_ADVANCE, ACT_HOLD
   } action_e;

   slot_t              slot_in, slot_nop, slot_d, slot_q;
   logic [CARRY_W-1:0] carry_d, carry_q;
   logic               up_stop, dn_stop;
   action_e            action;

   assign up_stop = stall[STAGE];

   // The last stage has no downstream stall bit to observe.
   if (STAGE + 1 < STALL_W) begin : g_dn
      assign dn_stop = stall[STAGE+1];
   end else begin : g_no_dn
      assign dn_stop = 1'b0;
   end

   always_comb begin
      if (rst)                       action = ACT_RESET;
      else if (flush)                action = ACT_FLUSH;
      else if (up_stop && !dn_stop)  action = ACT_BUBBLE;
      else if (!up_stop)             action = ACT_ADVANCE;
      else                           action = ACT_HOLD;
   end

   // An invalid slot must never write back, whatever the enables say.
   always_comb begin
      slot_in          = '{valid: in_valid, wd: in_wd, wreg: in_wreg & in_valid,
                           wdata: in_wdata, hi: in_hi, lo: in_lo,
                           whilo: in_whilo & in_valid, mem_addr: in_mem_addr,
                           reg2: in_reg2, aluop: in_aluop};
      slot_nop         = '0;
      slot_nop.aluop   = NOP_ALUOP;
   end

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      slot_d  = slot_q;
      carry_d = carry_i;
      unique case (action)
         ACT_RESET, ACT_FLUSH: begin
            slot_d  = slot_nop;
            carry_d = '0;
         end
         ACT_BUBBLE:  slot_d = slot_nop;
         ACT_ADVANCE: begin
            slot_d  = slot_in;
            carry_d = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      slot_q  <= slot_d;
      carry_q <= carry_d;
   end

   assign out_valid    = slot_q.valid;
   assign out_wd       = slot_q.wd;
   assign out_wreg     = slot_q.wreg;
   assign out_wdata    = slot_q.wdata;
   assign out_hi       = slot_q.hi;
   assign out_lo       = slot_q.lo;
   assign out_whilo    = slot_q.whilo;
   assign out_mem_addr = slot_q.mem_addr;
   assign out_reg2     = slot_q.reg2;
   assign out_aluop    = slot_q.aluop;
   assign carry_o      = carry_q;

`ifdef PIPE_REG_PERF_EN
   logic [PERF_W-1:0] bubble_cnt_d, bubble_cnt_q, hold_cnt_d, hold_cnt_q;

   // Saturating counters; flush leaves them alone, only rst clears them.
   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      hold_cnt_d   = hold_cnt_q;
      if (action == ACT_RESET) begin
         bubble_cnt_d = '0;
         hold_cnt_d   = '0;
      end else if (action == ACT_BUBBLE && !(&bubble_cnt_q)) begin
         bubble_cnt_d = bubble_cnt_q + PERF_W'(1);
      end else if (action == ACT_HOLD && !(&hold_cnt_q)) begin
         hold_cnt_d = hold_cnt_q + PERF_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      bubble_cnt_q <= bubble_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
   end

   assign bubble_cnt = bubble_cnt_q;
   assign hold_cnt   = hold_cnt_q;
`else
   assign bubble_cnt = '0;
   assign hold_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized self-checking bench for pipe_stage_reg against a cycle-level reference model.
// A second instance with PERF_W=2 exercises counter saturation.
module tb_pipe_stage_reg;

`ifdef PIPE_REG_PERF_EN
   localparam bit PERF_EN = 1'b1;
`else
   localparam bit PERF_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_wreg, in_whilo;
   logic [5:0]  stall;
   logic [4:0]  in_wd;
   logic [31:0] in_wdata, in_hi, in_lo, in_mem_addr, in_reg2;
   logic [7:0]  in_aluop;
   logic [65:0] carry_i;

   logic        out_valid, out_wreg, out_whilo;
   logic [4:0]  out_wd;
   logic [31:0] out_wdata, out_hi, out_lo, out_mem_addr, out_reg2;
   logic [7:0]  out_aluop;
   logic [65:0] carry_o;
   logic [15:0] bubble_cnt, hold_cnt;

   logic        s_valid, s_wreg, s_whilo;
   logic [4:0]  s_wd;
   logic [31:0] s_wdata, s_hi, s_lo, s_mem_addr, s_reg2;
   logic [7:0]  s_aluop;
   logic [65:0] s_carry;
   logic [1:0]  s_bubble_cnt, s_hold_cnt;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model state
   logic        m_valid, m_wreg, m_whilo;
   logic [4:0]  m_wd;
   logic [31:0] m_wdata, m_hi, m_lo, m_mem_addr, m_reg2;
   logic [7:0]  m_aluop;
   logic [65:0] m_carry;
   int          m_bub, m_hold, m_bub2;

   always #5 clk = ~clk;

   pipe_stage_reg dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata),
      .in_hi(in_hi), .in_lo(in_lo), .in_whilo(in_whilo), .in_mem_addr(in_mem_addr),
      .in_reg2(in_reg2), .in_aluop(in_aluop), .carry_i(carry_i),
      .out_valid(out_valid), .out_wd(out_wd), .out_wreg(out_wreg), .out_wdata(out_wdata),
      .out_hi(out_hi), .out_lo(out_lo), .out_whilo(out_whilo), .out_mem_addr(out_mem_addr),
      .out_reg2(out_reg2), .out_aluop(out_aluop), .carry_o(carry_o),
      .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
   );

   pipe_stage_reg #(.PERF_W(2)) dut_sat (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata),
      .in_hi(in_hi), .in_lo(in_lo), .in_whilo(in_whilo), .in_mem_addr(in_mem_addr),
      .in_reg2(in_reg2), .in_aluop(in_aluop), .carry_i(carry_i),
      .out_valid(s_valid), .out_wd(s_wd), .out_wreg(s_wreg), .out_wdata(s_wdata),
      .out_hi(s_hi), .out_lo(s_lo), .out_whilo(s_whilo), .out_mem_addr(s_mem_addr),
      .out_reg2(s_reg2), .out_aluop(s_aluop), .carry_o(s_carry),
      .bubble_cnt(s_bubble_cnt), .hold_cnt(s_hold_cnt)
   );

   function automatic int sat_inc(input int v, input int max);
      return (v >= max) ? max : v + 1;
   endfunction

   task automatic clear_model_slot();
      {m_valid, m_wd, m_wreg, m_wdata, m_hi, m_lo, m_whilo, m_mem_addr, m_reg2} = '0;
      m_aluop = 8'h00;
   endtask

   // One rising edge of behaviour, decided from the inputs present at that edge.
   task automatic model_edge();
      if (rst) begin
         clear_model_slot();
         m_carry = '0;
         m_bub = 0; m_hold = 0; m_bub2 = 0;
      end else if (flush) begin
         clear_model_slot();
         m_carry = '0;
      end else if (stall[3] && !stall[4]) begin
         clear_model_slot();
         m_carry = carry_i;
         m_bub   = sat_inc(m_bub, 65535);
         m_bub2  = sat_inc(m_bub2, 3);
      end else if (!stall[3]) begin
         m_valid = in_valid;  m_wd = in_wd;  m_wdata = in_wdata;
         m_hi = in_hi;  m_lo = in_lo;  m_mem_addr = in_mem_addr;
         m_reg2 = in_reg2;  m_aluop = in_aluop;
         m_wreg  = in_valid ? in_wreg : 1'b0;
         m_whilo = in_valid ? in_whilo : 1'b0;
         m_carry = '0;
      end else begin
         m_carry = carry_i;
         m_hold  = sat_inc(m_hold, 65535);
      end
   endtask

   function automatic logic [241:0] dut_vec();
      return {out_valid, out_wd, out_wreg, out_wdata, out_hi, out_lo, out_whilo,
              out_mem_addr, out_reg2, out_aluop, carry_o};
   endfunction

   function automatic logic [241:0] exp_vec();
      return {m_valid, m_wd, m_wreg, m_wdata, m_hi, m_lo, m_whilo,
              m_mem_addr, m_reg2, m_aluop, m_carry};
   endfunction

   function automatic logic [33:0] dut_cnt();
      return {bubble_cnt, hold_cnt, s_bubble_cnt};
   endfunction

   function automatic logic [33:0] exp_cnt();
      logic [33:0] v;
      v = {m_bub[15:0], m_hold[15:0], m_bub2[1:0]};
      return PERF_EN ? v : 34'd0;
   endfunction

   task automatic randomize_inputs();
      in_valid    = 1'($urandom);
      in_wd       = 5'($urandom);
      in_wreg     = 1'($urandom);
      in_wdata    = $urandom;
      in_hi       = $urandom;
      in_lo       = $urandom;
      in_whilo    = 1'($urandom);
      in_mem_addr = $urandom;
      in_reg2     = $urandom;
      in_aluop    = 8'($urandom);
      carry_i     = {2'($urandom_range(0, 3)), $urandom, $urandom};
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         randomize_inputs();
         stall = 6'($urandom);
         flush = 1'($urandom);
         step();
         tests_run++;
         if (dut_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL reset_state got %h want %h", dut_vec(), exp_vec());
         end
         tests_run++;
         if ({out_aluop, carry_o, out_valid, out_wreg} !== {8'h00, 66'd0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_nop got aluop=%h carry=%h valid=%b wreg=%b want 00/0/0/0",
                     out_aluop, carry_o, out_valid, out_wreg);
         end
         tests_run++;
         if (dut_cnt() !== 34'd0) begin
            tests_failed++;
            $display("FAIL reset_counters got %h want 0", dut_cnt());
         end
      end
      rst = 1'b0; flush = 1'b0; stall = '0;
   endtask

   task automatic test_advance();
      randomize_inputs();
      in_valid = 1'b1; in_wd = 5'd5; in_wdata = 32'hDEADBEEF; in_wreg = 1'b1;
      stall = '0;
      step();
      tests_run++;
      if ({out_wd, out_wdata, out_wreg, out_valid, carry_o} !==
          {5'd5, 32'hDEADBEEF, 1'b1, 1'b1, 66'd0}) begin
         tests_failed++;
         $display("FAIL advance_fields got wd=%0d wdata=%h wreg=%b valid=%b carry=%h want 5/DEADBEEF/1/1/0",
                  out_wd, out_wdata, out_wreg, out_valid, carry_o);
      end
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
         tests_failed++;
         $display("FAIL advance_all got %h want %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_bubble();
      logic [65:0] c;
      c = 66'h1_2345_6789_ABCD_EF01;
      stall = 6'b001111;
      for (int i = 0; i < 2; i++) begin
         randomize_inputs();
         carry_i = c;
         step();
         tests_run++;
         if ({out_valid, out_aluop, carry_o} !== {1'b0, 8'h00, c}) begin
            tests_failed++;
            $display("FAIL bubble_%0d got valid=%b aluop=%h carry=%h want 0/00/%h",
                     i, out_valid, out_aluop, carry_o, c);
         end
         tests_run++;
         if (dut_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL bubble_all_%0d got %h want %h", i, dut_vec(), exp_vec());
         end
      end
      stall = '0;
      randomize_inputs();
      step();
      tests_run++;
      if ({out_wdata, out_aluop, carry_o} !== {in_wdata, in_aluop, 66'd0}) begin
         tests_failed++;
         $display("FAIL bubble_resume got wdata=%h aluop=%h carry=%h want %h/%h/0",
                  out_wdata, out_aluop, carry_o, in_wdata, in_aluop);
      end
      tests_run++;
      if (bubble_cnt !== (PERF_EN ? 16'd2 : 16'd0)) begin
         tests_failed++;
         $display("FAIL bubble_count got %0d want %0d", bubble_cnt, PERF_EN ? 2 : 0);
      end
   endtask

   task automatic test_hold();
      randomize_inputs();
      in_valid = 1'b1; in_wdata = 32'h55; stall = '0;
      step();
      stall = 6'b011111;
      for (int i = 0; i < 3; i++) begin
         randomize_inputs();
         step();
         tests_run++;
         if ({out_wdata, carry_o} !== {32'h55, carry_i}) begin
            tests_failed++;
            $display("FAIL hold_%0d got wdata=%h carry=%h want 55/%h", i, out_wdata, carry_o, carry_i);
         end
         tests_run++;
         if (dut_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL hold_all_%0d got %h want %h", i, dut_vec(), exp_vec());
         end
      end
      tests_run++;
      if (hold_cnt !== (PERF_EN ? 16'd3 : 16'd0)) begin
         tests_failed++;
         $display("FAIL hold_count got %0d want %0d", hold_cnt, PERF_EN ? 3 : 0);
      end
   endtask

   task automatic test_flush();
      randomize_inputs();
      flush = 1'b1;
      step();
      flush = 1'b0;
      tests_run++;
      if ({out_wdata, out_valid, out_aluop, carry_o} !== {32'h0, 1'b0, 8'h00, 66'd0}) begin
         tests_failed++;
         $display("FAIL flush_clear got wdata=%h valid=%b aluop=%h carry=%h want 0/0/00/0",
                  out_wdata, out_valid, out_aluop, carry_o);
      end
      tests_run++;
      if ({bubble_cnt, hold_cnt} !== (PERF_EN ? {16'd2, 16'd3} : 32'd0)) begin
         tests_failed++;
         $display("FAIL flush_counters got %0d/%0d want %0d/%0d",
                  bubble_cnt, hold_cnt, PERF_EN ? 2 : 0, PERF_EN ? 3 : 0);
      end
   endtask

   task automatic test_invalid_and_saturate();
      randomize_inputs();
      in_valid = 1'b0; in_wreg = 1'b1; in_whilo = 1'b1; stall = '0;
      step();
      tests_run++;
      if ({out_wreg, out_whilo, out_valid} !== 3'b000) begin
         tests_failed++;
         $display("FAIL invalid_gating got wreg=%b whilo=%b valid=%b want 0/0/0",
                  out_wreg, out_whilo, out_valid);
      end
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
         tests_failed++;
         $display("FAIL invalid_all got %h want %h", dut_vec(), exp_vec());
      end
      stall = 6'b001111;
      for (int i = 0; i < 5; i++) begin
         randomize_inputs();
         step();
      end
      tests_run++;
      if ({s_bubble_cnt, bubble_cnt} !== (PERF_EN ? {2'b11, 16'd7} : 18'd0)) begin
         tests_failed++;
         $display("FAIL bubble_saturate got small=%0d main=%0d want %0d/%0d",
                  s_bubble_cnt, bubble_cnt, PERF_EN ? 3 : 0, PERF_EN ? 7 : 0);
      end
      stall = '0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         randomize_inputs();
         rst   = ($urandom_range(0, 49) == 0);
         flush = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 9) == 0)
            stall = 6'($urandom);
         else
            stall = 6'((1 << $urandom_range(0, 6)) - 1);
         step();
         tests_run++;
         if ({dut_vec(), dut_cnt()} !== {exp_vec(), exp_cnt()}) begin
            tests_failed++;
            $display("FAIL random_%0d got %h/%h want %h/%h", i, dut_vec(), dut_cnt(),
                     exp_vec(), exp_cnt());
         end
      end
      rst = 1'b0; flush = 1'b0; stall = '0;
   endtask

   initial begin
      {m_valid, m_wd, m_wreg, m_wdata, m_hi, m_lo, m_whilo, m_mem_addr, m_reg2, m_aluop, m_carry} = '0;
      m_bub = 0; m_hold = 0; m_bub2 = 0;
      rst = 1'b1; flush = 1'b0; stall = '0;
      randomize_inputs();
      test_reset();
      test_advance();
      test_bubble();
      test_hold();
      test_flush();
      test_invalid_and_saturate();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got no finish want finish before 100000");
      $fatal(1, "timeout");
   end

endmodule
